// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer: reads DUMP_SIZE bytes of memory from BASE_ADDR one word at a
// time and emits them as a little-endian byte stream. The stream is framed into
// SECTOR_BYTES sectors, and the final partial sector is filled with zero bytes.
module mem_dump_streamer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          DUMP_SIZE    = 4096,
  parameter int          SECTOR_BYTES = 512
) (
  input  logic        clk27mhz,
  input  logic        resetn,
  input  logic        start,
  output logic        RE,
  output logic [31:0] ADDR,
  input  logic [7:0]  w_ctrl_state,
  input  logic [31:0] RDATA,
  output logic [7:0]  outbyte,
  output logic        outen,
  input  logic        outready,
  output logic        sector_last,
  output logic        BUSY,
  output logic        DONE
);
  localparam int NWORDS    = DUMP_SIZE / 4;
  localparam int WI_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int SC_W      = $clog2(SECTOR_BYTES);
  localparam int PAD_BYTES = (SECTOR_BYTES - (DUMP_SIZE % SECTOR_BYTES)) % SECTOR_BYTES;
  localparam logic [WI_W-1:0] LAST_WI  = WI_W'(NWORDS - 1);
  localparam logic [SC_W-1:0] PAD_INIT = SC_W'(PAD_BYTES);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK, S_WAIT, S_EMIT, S_PAD, S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [WI_W-1:0]   wi;      // word index
  logic [1:0]        bi;      // byte within the held word
  logic [SC_W-1:0]   sc;      // byte position inside the current sector
  logic [SC_W-1:0]   pr;      // pad bytes still owed
  logic [31:0]       hold;    // word being unpacked
  logic              done_r;
  logic              accept;

  assign accept = outen && outready;

  // State register
  always_ff @(posedge clk27mhz) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ:  if (w_ctrl_state == 8'd0) state_nxt = S_ACK;
      S_ACK:  if (w_ctrl_state != 8'd0) state_nxt = S_WAIT;
      S_WAIT: if (w_ctrl_state == 8'd0) state_nxt = S_EMIT;
      S_EMIT: begin
        if (outready && bi == 2'd3) begin
          if (wi == LAST_WI) state_nxt = (PAD_BYTES != 0) ? S_PAD : S_FIN;
          else               state_nxt = S_REQ;
        end
      end
      S_PAD:  if (outready && pr == SC_W'(1)) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters, holding register and sticky completion flag
  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      wi     <= '0;
      bi     <= '0;
      sc     <= '0;
      pr     <= PAD_INIT;
      hold   <= '0;
      done_r <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        wi     <= '0;
        sc     <= '0;
        pr     <= PAD_INIT;
        done_r <= 1'b0;
      end
      if (state == S_WAIT && w_ctrl_state == 8'd0) begin
        hold <= RDATA;
        bi   <= '0;
      end
      if (accept) sc <= sc + SC_W'(1);
      if (state == S_EMIT && accept) begin
        bi <= bi + 2'd1;
        if (bi == 2'd3 && wi != LAST_WI) wi <= wi + WI_W'(1);
      end
      if (state == S_PAD && accept) pr <= pr - SC_W'(1);
      // Set on the edge that accepts the final byte, so DONE is already high in FIN
      if (state_nxt == S_FIN) done_r <= 1'b1;
    end
  end

  // Outputs decoded from registered state only, so they hold steady across stalls
  always_comb begin
    RE          = (state == S_ACK);
    ADDR        = BASE_ADDR + (32'(wi) << 2);
    outen       = (state == S_EMIT) || (state == S_PAD);
    outbyte     = (state == S_EMIT) ? hold[{bi, 3'b000} +: 8] : 8'h00;
    sector_last = outen && (sc == SC_LAST);
    BUSY        = (state != S_IDLE) && (state != S_FIN);
    DONE        = done_r;
  end
endmodule

// File: tb/tb_mem_dump_streamer.sv
// Bench for mem_dump_streamer: two instances (8-byte dump with padding, 1024-byte
// dump filling two sectors), each with a randomized memory-controller model and
// a byte-stream scoreboard derived from the memory contents.
module tb_mem_dump_streamer;
  localparam logic [31:0] BASE0 = 32'h0000_1000;
  localparam logic [31:0] BASE1 = 32'h2000_0000;
  localparam int DS0 = 8;
  localparam int DS1 = 1024;
  localparam int SEC = 512;
  localparam logic [31:0] BASE [2] = '{BASE0, BASE1};
  localparam int DS  [2] = '{DS0, DS1};
  localparam int TOT [2] = '{512, 1024};   // dump rounded up to whole sectors
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn_s   [2];
  logic        start_s    [2];
  logic        re_s       [2];
  logic [31:0] addr_s     [2];
  logic [7:0]  ctrl_s     [2] = '{8'd0, 8'd0};
  logic [31:0] rdata_s    [2] = '{32'd0, 32'd0};
  logic [7:0]  outbyte_s  [2];
  logic        outen_s    [2];
  logic        outready_s [2] = '{1'b1, 1'b1};
  logic        sl_s       [2];
  logic        busy_s     [2];
  logic        done_s     [2];

  mem_dump_streamer #(.BASE_ADDR(BASE0), .DUMP_SIZE(DS0), .SECTOR_BYTES(SEC)) u_small (
    .clk27mhz(clk), .resetn(resetn_s[0]), .start(start_s[0]), .RE(re_s[0]), .ADDR(addr_s[0]),
    .w_ctrl_state(ctrl_s[0]), .RDATA(rdata_s[0]), .outbyte(outbyte_s[0]), .outen(outen_s[0]),
    .outready(outready_s[0]), .sector_last(sl_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]));

  mem_dump_streamer #(.BASE_ADDR(BASE1), .DUMP_SIZE(DS1), .SECTOR_BYTES(SEC)) u_big (
    .clk27mhz(clk), .resetn(resetn_s[1]), .start(start_s[1]), .RE(re_s[1]), .ADDR(addr_s[1]),
    .w_ctrl_state(ctrl_s[1]), .RDATA(rdata_s[1]), .outbyte(outbyte_s[1]), .outen(outen_s[1]),
    .outready(outready_s[1]), .sector_last(sl_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]));

  logic [31:0] mem0 [2];
  logic [31:0] mem1 [256];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_until [2] = '{0, 0};
  bit rdy_rnd    [2] = '{1'b0, 1'b0};
  bit pend       [2] = '{1'b0, 1'b0};
  int lat        [2] = '{0, 0};
  logic [31:0] lat_addr [2];
  logic [7:0]  cs_prev  [2] = '{8'd0, 8'd0};
  int pos   [2] = '{0, 0};
  int rises [2] = '{0, 0};
  bit re_q  [2] = '{1'b0, 1'b0};
  bit hold_v [2] = '{1'b0, 1'b0};
  logic [7:0] hold_b [2];
  logic hold_sl [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int k, input logic [31:0] a);
    int idx;
    idx = int'((a - BASE[k]) >> 2);
    return (k == 0) ? mem0[idx % 2] : mem1[idx % 256];
  endfunction

  // Expected stream byte p: memory bytes little-endian, then zero padding
  function automatic logic [7:0] exp_byte(input int k, input int p);
    logic [31:0] w;
    if (p >= DS[k]) return 8'h00;
    w = (k == 0) ? mem0[(p / 4) % 2] : mem1[(p / 4) % 256];
    return w[8 * (p % 4) +: 8];
  endfunction

  // Memory-controller model: accepts RE when idle, busy for 1..3 cycles, returns data
  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      cs_prev[k] <= ctrl_s[k];
      if (!resetn_s[k]) begin
        pend[k]   <= 1'b0;
        ctrl_s[k] <= 8'd0;
      end else if (cyc < busy_until[k]) begin
        ctrl_s[k] <= 8'd5;
      end else if (pend[k]) begin
        if (lat[k] == 0) begin
          ctrl_s[k]  <= 8'd0;
          rdata_s[k] <= mem_rd(k, lat_addr[k]);
          pend[k]    <= 1'b0;
        end else lat[k] <= lat[k] - 1;
      end else if (re_s[k] && ctrl_s[k] == 8'd0) begin
        pend[k]     <= 1'b1;
        lat[k]      <= int'($urandom_range(0, 2));
        lat_addr[k] <= addr_s[k];
        ctrl_s[k]   <= 8'd3;
      end else ctrl_s[k] <= 8'd0;
    end
  end

  // Stream / request monitor plus outready driver
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      outready_s[k] = rdy_rnd[k] ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!busy_s[k]) begin
        pos[k] = 0; rises[k] = 0; hold_v[k] = 1'b0; re_q[k] = 1'b0;
      end else begin
        if (re_s[k] && !re_q[k]) begin
          chk("req_addr", addr_s[k], BASE[k] + 32'(4 * rises[k]));
          chk("req_ctrl_idle", {24'd0, cs_prev[k]}, 32'd0);
          chk("req_outstanding", {31'd0, pend[k]}, 32'd0);
          rises[k]++;
        end
        re_q[k] = re_s[k];
        if (hold_v[k]) begin
          chk("stall_outen", {31'd0, outen_s[k]}, 32'd1);
          chk("stall_byte", {24'd0, outbyte_s[k]}, {24'd0, hold_b[k]});
          chk("stall_last", {31'd0, sl_s[k]}, {31'd0, hold_sl[k]});
        end
        if (outen_s[k]) begin
          chk("overrun", {31'd0, pos[k] < TOT[k]}, 32'd1);
          chk("byte", {24'd0, outbyte_s[k]}, {24'd0, exp_byte(k, pos[k])});
          chk("sector_last", {31'd0, sl_s[k]}, {31'd0, (pos[k] % SEC) == SEC - 1});
        end else begin
          chk("sector_last_idle", {31'd0, sl_s[k]}, 32'd0);
        end
        hold_v[k]  = outen_s[k] && !outready_s[k];
        hold_b[k]  = outbyte_s[k];
        hold_sl[k] = sl_s[k];
        if (outen_s[k] && outready_s[k]) pos[k]++;
      end
    end
  end

  task automatic pulse_start(input int k);
    @(posedge clk); #1 start_s[k] = 1'b1;
    @(posedge clk); #1 start_s[k] = 1'b0;
    chk("start_busy", {31'd0, busy_s[k]}, 32'd1);
    chk("start_done", {31'd0, done_s[k]}, 32'd0);
    chk("start_addr", addr_s[k], BASE[k]);
  endtask

  task automatic run_dump(input int k, input bit rnd, input int poke, input int busy);
    bit seen_re = 1'b0;
    rdy_rnd[k] = rnd;
    if (busy > 0) busy_until[k] = cyc + busy;
    pulse_start(k);
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk); #1;
      if (pos[k] == TOT[k]) break;
      start_s[k] = (poke > 0 && pos[k] == poke);
      if (!seen_re && re_s[k]) begin
        seen_re = 1'b1;
        if (busy > 0) chk("ctrl_busy_hold", {31'd0, cyc > busy_until[k]}, 32'd1);
      end
    end
    start_s[k] = 1'b0;
    chk("stream_len", pos[k], TOT[k]);
    chk("req_count", rises[k], DS[k] / 4);
    chk("done_set", {31'd0, done_s[k]}, 32'd1);
    chk("busy_clear", {31'd0, busy_s[k]}, 32'd0);
    chk("outen_clear", {31'd0, outen_s[k]}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("done_hold", {31'd0, done_s[k]}, 32'd1);
  endtask

  task automatic reset_mid(input int k);
    rdy_rnd[k] = 1'b0;
    pulse_start(k);
    for (int n = 0; n < BUDGET; n++) begin
      @(posedge clk); #1;
      if (pos[k] == 12 && outen_s[k]) break;
    end
    chk("reached_word3", pos[k], 12);
    resetn_s[k] = 1'b0;
    @(posedge clk); #1;
    chk("rst_re", {31'd0, re_s[k]}, 32'd0);
    chk("rst_outen", {31'd0, outen_s[k]}, 32'd0);
    chk("rst_busy", {31'd0, busy_s[k]}, 32'd0);
    chk("rst_done", {31'd0, done_s[k]}, 32'd0);
    chk("rst_addr", addr_s[k], BASE[k]);
    resetn_s[k] = 1'b1;
  endtask

  initial begin
    resetn_s = '{1'b0, 1'b0};
    start_s  = '{1'b0, 1'b0};
    mem0[0] = 32'h4433_2211;
    mem0[1] = 32'h8877_6655;
    for (int i = 0; i < 256; i++)
      mem1[i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_re", {31'd0, re_s[k]}, 32'd0);
      chk("reset_addr", addr_s[k], BASE[k]);
      chk("reset_outbyte", {24'd0, outbyte_s[k]}, 32'd0);
      chk("reset_outen", {31'd0, outen_s[k]}, 32'd0);
      chk("reset_sector_last", {31'd0, sl_s[k]}, 32'd0);
      chk("reset_busy", {31'd0, busy_s[k]}, 32'd0);
      chk("reset_done", {31'd0, done_s[k]}, 32'd0);
    end
    resetn_s = '{1'b1, 1'b1};

    run_dump(0, 1'b0, 0, 0);      // 8 bytes + 504 pad, outready tied high
    run_dump(0, 1'b1, 3, 0);      // same stream under backpressure, start poked mid-dump
    run_dump(1, 1'b0, 0, 0);      // 1024 incrementing bytes, two full sectors
    for (int i = 0; i < 256; i++) mem1[i] = $urandom();
    run_dump(1, 1'b1, 100, 20);   // controller busy at start, random data and stalls
    reset_mid(1);
    run_dump(1, 1'b1, 0, 0);      // fresh dump after the abandoned one

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_dump_streamer.md
# mem_dump_streamer

Reads a contiguous region of main memory word by word through the memory-controller request handshake. Unpacks each 32-bit word into a little-endian byte stream with a valid/ready handshake toward a byte sink, normally the SD sector writer. The stream is framed into fixed-size sectors, and the final partial sector is zero-padded. It is the outbound counterpart of the SD boot loader: memory → bytes → SD card.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, first byte address dumped; must be 4-byte aligned.
- DUMP_SIZE, 4096, bytes to dump; multiple of 4, ≥ 4.
- SECTOR_BYTES, 512, sector length for framing and padding; power of two, ≥ 4.

Ports:
- clk27mhz  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- RE  out  1  read request to memory controller.
- ADDR  out  32  byte address of the requested word.
- w_ctrl_state  in  8  memory-controller state; 0 = idle.
- RDATA  in  32  read data; valid when w_ctrl_state returns to 0 after acceptance.
- outbyte  out  8  stream byte.
- outen  out  1  outbyte valid.
- outready  in  1  sink accepts byte when outen && outready at a clock edge.
- sector_last  out  1  high together with outen on the last byte of each sector.
- BUSY  out  1  dump in progress.
- DONE  out  1  sticky completion flag.

## Operation
- Counters:
  - word index wi, 0..DUMP_SIZE/4-1.
  - byte-in-word bi, 2 bits.
  - sector byte count sc, log2(SECTOR_BYTES) bits, wraps to 0.
  - pad remaining pr = (SECTOR_BYTES - DUMP_SIZE mod SECTOR_BYTES) mod SECTOR_BYTES, computed at elaboration.
- ADDR = BASE_ADDR + 4*wi, 32-bit arithmetic with wrap. ADDR is stable whenever RE = 1.
- States:
  - IDLE: start=1 → clear DONE, wi=0, sc=0, BUSY=1 → REQ.
  - REQ: wait for w_ctrl_state==0, then assert RE → ACK.
  - ACK: RE held until w_ctrl_state!=0. Then drop RE → WAIT.
  - WAIT: on w_ctrl_state==0, capture RDATA into a 32-bit holding register, bi=0 → EMIT.
  - EMIT: outen=1, outbyte = hold[8*bi+7:8*bi]. On each accepted byte:
    - increment sc.
    - increment bi.
    - after bi=3: if wi is the last word, go to PAD when pr≠0, else FIN. Otherwise wi+1 → REQ.
  - PAD: outen=1, outbyte=8'h00; decrement pr on each accept; at 0 → FIN.
  - FIN: BUSY=0, DONE=1 → IDLE.
- sector_last = outen && (sc == SECTOR_BYTES-1), in both EMIT and PAD.
- Holding outen: outbyte, outen and sector_last stay constant while outen && !outready.
- start while BUSY: ignored.
- start in the same cycle DONE would set (FIN): ignored; the start is accepted the following IDLE cycle only if still asserted.
- Reset mid-operation: on the next edge all outputs go to reset values and state = IDLE. An outstanding controller request is abandoned; RE drops immediately.

## Timing
- Reset values: RE=0, ADDR=BASE_ADDR, outbyte=0, outen=0, sector_last=0, BUSY=0, DONE=0.
- start sampled at edge N → BUSY=1 after N. RE=1 after N+1 if w_ctrl_state==0 at N+1.
- RE deasserts on the edge after w_ctrl_state!=0 is first seen. RE stays high for at least 1 cycle.
- RDATA is captured on the first edge with w_ctrl_state==0 in WAIT. outen=1 after that edge.
- Outputs are registered; outen can be high no earlier than 1 cycle after capture.
- With outready tied 1 and a 2-cycle controller: 4 bytes at 1 byte/clock, then ≥3 cycles of RE/ACK/WAIT before the next byte.
- DONE rises on the edge after the last accepted byte, including pad bytes. DONE holds until the next accepted start or reset.

## Test plan
- DUMP_SIZE=8, words 0x44332211, 0x88776655, outready=1:
  - stream is 11 22 33 44 55 66 77 88, then 504×00.
  - sector_last only on byte 512.
  - ADDR sequence BASE, BASE+4.
  - DONE=1.
- Backpressure with outready pseudo-random (~50%): byte sequence identical to the outready=1 run; outbyte stable across every stall cycle; no byte dropped or duplicated.
- DUMP_SIZE=1024, SECTOR_BYTES=512, incrementing data:
  - exactly 1024 bytes, no padding.
  - sector_last at bytes 512 and 1024.
  - 256 RE requests.
- Controller busy: w_ctrl_state=5 for 20 cycles at start → RE stays 0 until w_ctrl_state==0. Then RE pulses once per word; no second request while a request is outstanding.
- start pulsed mid-dump is ignored (ADDR continues). start after DONE restarts with ADDR=BASE_ADDR, DONE=0, BUSY=1.
- resetn=0 during EMIT of word 3 → next edge: RE=0, outen=0, BUSY=0, DONE=0. A new start dumps from BASE_ADDR.
